// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
//   Shares one external 32-bit SRAM between instruction fetch (IF) and the
//   MEM stage. MEM has priority. Each access holds the SRAM strobes for
//   WAIT_CYCLES+1 cycles and then returns to IDLE. The IDLE cycle that follows
//   is the cycle in which the one-cycle ack/valid pulse is high.
//
//   Optional feature: define SRAM_ARB_PERF_EN to add the perf_if_stall and
//   perf_mem_cnt counters.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   if_ce, if_addr        fetch request and byte address, held until if_valid
//   if_inst, if_valid     fetched word and its one-cycle completion pulse
//   mem_req, mem_we       MEM request (held until mem_ack), 1 = store
//   mem_addr, mem_be      data byte address and store byte enables
//   mem_wdata             store data
//   mem_rdata, mem_ack    load data and its one-cycle completion pulse
//   stall_o               combinational pipeline stall
//   ram_*                 SRAM word address, data, tri-state enable and
//                         active-low strobes
//   fsm_state             current FSM state, for observation
//   perf_if_stall         cycles with a fetch pending (SRAM_ARB_PERF_EN only)
//   perf_mem_cnt          completed MEM accesses (SRAM_ARB_PERF_EN only)
//
// Handshake: a requester raises its request with stable fields and holds
// them until it sees its ack/valid pulse. It drops the request, or presents
// the next request, within the pulse cycle. The arbiter samples requests at
// every edge while it is in IDLE, including the edge that ends the pulse
// cycle.
module sram_bus_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_ce,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_inst,
    output logic              if_valid,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [3:0]        mem_be,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ack,
    output logic              stall_o,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_wdata_oe,
    input  logic [31:0]       ram_rdata,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [3:0]        ram_be_n,
    output logic [1:0]        fsm_state
`ifdef SRAM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_stall,
    output logic [31:0]       perf_mem_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_ACC  = 2'd1,
        MEM_ACC = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    state_t     state;
    logic [3:0] cnt;

    // Byte-offset bits and bits above the SRAM word range are not used.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    assign stall_o   = (if_ce & ~if_valid) | (mem_req & ~mem_ack);
    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            ram_ce_n     <= 1'b1;
            ram_oe_n     <= 1'b1;
            ram_we_n     <= 1'b1;
            ram_be_n     <= 4'hF;
            ram_wdata_oe <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= 32'd0;
            if_valid     <= 1'b0;
            mem_ack      <= 1'b0;
            if_inst      <= 32'd0;
            mem_rdata    <= 32'd0;
        end else begin
            if_valid <= 1'b0;
            mem_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    if (mem_req) begin
                        state    <= MEM_ACC;
                        ram_addr <= mem_addr[ADDR_W+1:2];
                        ram_ce_n <= 1'b0;
                        if (mem_we) begin
                            ram_we_n     <= 1'b0;
                            ram_be_n     <= ~mem_be;
                            ram_wdata    <= mem_wdata;
                            ram_wdata_oe <= 1'b1;
                        end else begin
                            // Loads read the whole word; the MEM stage extracts bytes.
                            ram_oe_n <= 1'b0;
                            ram_be_n <= 4'h0;
                        end
                    end else if (if_ce) begin
                        state    <= IF_ACC;
                        ram_addr <= if_addr[ADDR_W+1:2];
                        ram_ce_n <= 1'b0;
                        ram_oe_n <= 1'b0;
                        ram_be_n <= 4'h0;
                    end
                end
                IF_ACC, MEM_ACC: begin
                    if (cnt == WAIT_LAST) begin
                        state        <= IDLE;
                        cnt          <= 4'd0;
                        ram_ce_n     <= 1'b1;
                        ram_oe_n     <= 1'b1;
                        ram_we_n     <= 1'b1;
                        ram_be_n     <= 4'hF;
                        ram_wdata_oe <= 1'b0;
                        if (state == IF_ACC) begin
                            if_inst  <= ram_rdata;
                            if_valid <= 1'b1;
                        end else begin
                            // ram_we_n still low here means this access was a store.
                            if (ram_we_n) mem_rdata <= ram_rdata;
                            mem_ack <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SRAM_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_if_stall <= 32'd0;
            perf_mem_cnt  <= 32'd0;
        end else begin
            if (if_ce & ~if_valid) perf_if_stall <= perf_if_stall + 32'd1;
            if (mem_ack)           perf_mem_cnt  <= perf_mem_cnt + 32'd1;
        end
    end
`endif

endmodule
